// File: rtl/mlp_argmax_classifier_if.sv
// Stream bundle between the MLP output layer, the argmax classifier and its consumer.
// Score beats flow in on in_*; the classification result leaves on out_*.
interface mlp_argmax_classifier_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_score;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_class;
  logic [DATA_W-1:0] out_score;
  logic [DATA_W:0]   out_margin;
  logic              out_err;

  modport master (
    output in_valid, in_score, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_margin, out_err
  );

  modport slave (
    input  in_valid, in_score, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score, out_margin, out_err
  );
endinterface

// File: rtl/mlp_argmax_classifier.sv
// Argmax over one frame of NUM_CLASSES serial signed scores; reports winning class,
// winning score, the margin to the runner-up and a frame-length error flag.
module mlp_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  mlp_argmax_classifier_if.slave      bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0]         IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]         IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                     state_q,      state_d;
  logic [IDX_W-1:0]           count_q,      count_d;
  logic signed [DATA_W-1:0]   best_q,       best_d;
  logic [IDX_W-1:0]           best_idx_q,   best_idx_d;
  logic signed [DATA_W-1:0]   second_q,     second_d;
  logic                       err_q,        err_d;
  logic                       in_ready_q,   in_ready_d;
  logic                       out_valid_q,  out_valid_d;
  logic [IDX_W-1:0]           out_class_q,  out_class_d;
  logic [DATA_W-1:0]          out_score_q,  out_score_d;
  logic [DATA_W:0]            out_margin_q, out_margin_d;
  logic                       out_err_q,    out_err_d;

  logic                       accept_s;
  logic                       is_final_s;
  logic signed [DATA_W-1:0]   score_s;
  logic signed [DATA_W:0]     margin_s;

  assign accept_s   = bus.in_valid && in_ready_q;
  assign is_final_s = (count_q == LAST_IDX);
  assign score_s    = $signed(bus.in_score);

  // Next-state, running max/second-max tracking and result capture.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    second_d     = second_q;
    err_d        = err_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    out_margin_d = out_margin_q;
    out_err_d    = out_err_q;
    margin_s     = {(DATA_W+1){1'b0}};

    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          if (count_q == IDX_ZERO) begin
            best_d     = score_s;
            best_idx_d = IDX_ZERO;
            second_d   = SCORE_MIN;
            err_d      = bus.in_last;
          end else if (score_s > best_q) begin
            second_d   = best_q;
            best_d     = score_s;
            best_idx_d = count_q;
            err_d      = err_q | (bus.in_last & ~is_final_s) | (~bus.in_last & is_final_s);
          end else if (score_s > second_q) begin
            second_d   = score_s;
            err_d      = err_q | (bus.in_last & ~is_final_s) | (~bus.in_last & is_final_s);
          end else begin
            err_d      = err_q | (bus.in_last & ~is_final_s) | (~bus.in_last & is_final_s);
          end

          // Sign-extend both operands so the difference never wraps.
          margin_s = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};

          if (is_final_s) begin
            state_d      = DONE;
            count_d      = IDX_ZERO;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_class_d  = best_idx_d;
            out_score_d  = best_d;
            out_margin_d = margin_s;
            out_err_d    = err_d;
          end else begin
            count_d = count_q + IDX_ONE;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = ACCUM;
        count_d     = IDX_ZERO;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      count_q      <= IDX_ZERO;
      best_q       <= {DATA_W{1'b0}};
      best_idx_q   <= IDX_ZERO;
      second_q     <= SCORE_MIN;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_class_q  <= IDX_ZERO;
      out_score_q  <= {DATA_W{1'b0}};
      out_margin_q <= {(DATA_W+1){1'b0}};
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      second_q     <= second_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_margin_q <= out_margin_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_class  = out_class_q;
  assign bus.out_score  = out_score_q;
  assign bus.out_margin = out_margin_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_mlp_argmax_classifier.sv
// Directed bench for mlp_argmax_classifier: hand-computed frames, backpressure,
// frame-length errors, margin extremes and resets mid-frame / while holding a result.
module tb_mlp_argmax_classifier;

  typedef logic [15:0] frame_t [10];

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  mlp_argmax_classifier_if #(.DATA_W(16), .IDX_W(4)) bus ();

  mlp_argmax_classifier #(
    .NUM_CLASSES (10),
    .DATA_W      (16),
    .IDX_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the first n beats of a frame; checks latency when the full frame is sent.
  task automatic send_beats(input frame_t s, input logic [9:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (!bus.in_ready && w < 20) begin
        tick();
        w++;
      end
      check_eq("in_ready_beat", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_score = s[i];
      bus.in_last  = l[i];
      if (i == 9) check_eq("valid_before_last", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_score = 16'h0000;
  endtask

  task automatic check_result(input string tag, input logic [3:0] cls, input logic [15:0] sc,
                              input logic [16:0] mg, input logic err);
    check_eq({tag, "_valid"},  {31'd0, bus.out_valid},  32'd1);
    check_eq({tag, "_ready"},  {31'd0, bus.in_ready},   32'd0);
    check_eq({tag, "_class"},  {28'd0, bus.out_class},  {28'd0, cls});
    check_eq({tag, "_score"},  {16'd0, bus.out_score},  {16'd0, sc});
    check_eq({tag, "_margin"}, {15'd0, bus.out_margin}, {15'd0, mg});
    check_eq({tag, "_err"},    {31'd0, bus.out_err},    {31'd0, err});
  endtask

  task automatic handoff(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_ho_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_ho_ready"}, {31'd0, bus.in_ready},  32'd1);
  endtask

  frame_t f_main, f_neg, f_tie, f_wide, f_abort, f_clean;

  initial begin
    n_total = 0;
    n_bad   = 0;
    bus.in_valid  = 1'b0;
    bus.in_score  = 16'h0000;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;

    f_main  = '{16'h0100, 16'h0200, 16'hFF00, 16'h0900, 16'h0050,
                16'h0000, 16'h0300, 16'h0100, 16'h0080, 16'h0010};
    f_neg   = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    f_tie   = '{16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000};
    f_wide  = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    f_abort = '{16'h0000, 16'h7000, 16'h6000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    f_clean = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0200,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_in_ready",  {31'd0, bus.in_ready},   32'd1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid},  32'd0);
    check_eq("rst_class",     {28'd0, bus.out_class},  32'd0);
    check_eq("rst_score",     {16'd0, bus.out_score},  32'd0);
    check_eq("rst_margin",    {15'd0, bus.out_margin}, 32'd0);
    check_eq("rst_err",       {31'd0, bus.out_err},    32'd0);

    send_beats(f_main, 10'b10_0000_0000, 10);
    check_result("main", 4'd3, 16'h0900, 17'h00600, 1'b0);
    handoff("main");

    send_beats(f_neg, 10'b10_0000_0000, 10);
    check_result("neg", 4'd9, 16'hFFFF, 17'h07FFF, 1'b0);
    handoff("neg");

    send_beats(f_tie, 10'b10_0000_0000, 10);
    check_result("tie", 4'd2, 16'h0400, 17'h00000, 1'b0);
    handoff("tie");

    send_beats(f_wide, 10'b10_0000_0000, 10);
    check_result("wide", 4'd0, 16'h7FFF, 17'h0FFFF, 1'b0);
    handoff("wide");

    send_beats(f_main, 10'b10_0001_0000, 10);
    check_result("early_last", 4'd3, 16'h0900, 17'h00600, 1'b1);
    handoff("early_last");

    send_beats(f_main, 10'b00_0000_0000, 10);
    check_result("no_last", 4'd3, 16'h0900, 17'h00600, 1'b1);
    handoff("no_last");

    // Backpressure: result must hold and junk beats must be ignored.
    send_beats(f_main, 10'b10_0000_0000, 10);
    bus.in_valid = 1'b1;
    bus.in_score = 16'h7FFF;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_result("hold", 4'd3, 16'h0900, 17'h00600, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    check_eq("hold_ho_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("hold_ho_ready", {31'd0, bus.in_ready},  32'd1);
    send_beats(f_tie, 10'b10_0000_0000, 10);
    check_result("after_hold", 4'd2, 16'h0400, 17'h00000, 1'b0);
    handoff("after_hold");

    // Reset mid-frame after beat 5.
    send_beats(f_abort, 10'b00_0000_0000, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, bus.in_ready},  32'd1);
    check_eq("mid_rst_class", {28'd0, bus.out_class}, 32'd0);
    check_eq("mid_rst_score", {16'd0, bus.out_score}, 32'd0);
    send_beats(f_clean, 10'b10_0000_0000, 10);
    check_result("clean", 4'd4, 16'h0200, 17'h00100, 1'b0);

    // Reset while holding a result.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("done_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("done_rst_ready", {31'd0, bus.in_ready},  32'd1);
    check_eq("done_rst_err",   {31'd0, bus.out_err},   32'd0);

    send_beats(f_main, 10'b10_0000_0000, 10);
    check_result("post_rst", 4'd3, 16'h0900, 17'h00600, 1'b0);
    handoff("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
